// File: rtl/pipe_adder_pkg.sv
// Shared constants for the chunked pipelined adder.
// Holds the mode encodings, the default geometry and the stage-0 carry selection.
package pipe_adder_pkg;

  localparam int unsigned DEFAULT_N     = 16;
  localparam int unsigned DEFAULT_CHUNK = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Subtraction is a + ~b + 1, so the "+1" enters as the stage-0 carry.
  function automatic logic stage0_carry(logic mode, logic cin);
    return (mode == MODE_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice for one pipeline stage.
// c_msb is the carry into the slice MSB, used for signed overflow detection.
module add_chunk
  import pipe_adder_pkg::*;
#(
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

  assign sum   = full[CHUNK-1:0];
  assign cout  = full[CHUNK];
  assign c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/pipe_adder_gen.sv
// Pipelined N-bit adder/subtractor, CHUNK bits resolved per stage, with a
// valid/ready handshake and a single global advance enable.
module pipe_adder_gen
  import pipe_adder_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   s,
  output logic         ovf
);

  localparam int unsigned STAGES = N / CHUNK;

  if ((N % CHUNK) != 0 || CHUNK > N) begin : g_bad_params
    $error("pipe_adder_gen: N must be a non-zero multiple of CHUNK");
  end

  // Register set k feeds adder stage k; set STAGES is the output register.
  logic [STAGES:0]             v_q;
  logic [STAGES:0]             c_q;
  logic [STAGES:0][N-1:0]      sum_q;
  logic [STAGES-1:0][N-1:0]    a_q;
  logic [STAGES-1:0][N-1:0]    b_q;
  logic                        ovf_q;

  logic [STAGES-1:0][CHUNK-1:0] chunk_sum;
  logic [STAGES-1:0]            chunk_cout;
  logic [STAGES-1:0]            chunk_cmsb;
  logic                         en;

  assign en        = !v_q[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[STAGES];
  assign s         = {c_q[STAGES], sum_q[STAGES]};
  assign ovf       = ovf_q;

  // Only the top slice's MSB carry matters for overflow.
  logic unused_cmsb;
  assign unused_cmsb = ^chunk_cmsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q[0]   <= 1'b0;
      c_q[0]   <= 1'b0;
      a_q[0]   <= '0;
      b_q[0]   <= '0;
      sum_q[0] <= '0;
      ovf_q    <= 1'b0;
    end else if (en) begin
      v_q[0]   <= in_valid;
      c_q[0]   <= stage0_carry(mode, cin);
      a_q[0]   <= a;
      b_q[0]   <= (mode == MODE_SUB) ? ~b : b;
      sum_q[0] <= '0;
      ovf_q    <= chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_chunk #(
      .CHUNK(CHUNK)
    ) u_add (
      .a    (a_q[k][k*CHUNK +: CHUNK]),
      .b    (b_q[k][k*CHUNK +: CHUNK]),
      .cin  (c_q[k]),
      .sum  (chunk_sum[k]),
      .cout (chunk_cout[k]),
      .c_msb(chunk_cmsb[k])
    );

    // Deskew: finished low chunks ride along, this stage fills in chunk k.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k+1]   <= 1'b0;
        c_q[k+1]   <= 1'b0;
        sum_q[k+1] <= '0;
      end else if (en) begin
        v_q[k+1]                     <= v_q[k];
        c_q[k+1]                     <= chunk_cout[k];
        sum_q[k+1]                   <= sum_q[k];
        sum_q[k+1][k*CHUNK +: CHUNK] <= chunk_sum[k];
      end
    end

    // Skew: operands travel on until their top chunk has been consumed.
    if (k + 1 < STAGES) begin : g_fwd
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q[k+1] <= '0;
          b_q[k+1] <= '0;
        end else if (en) begin
          a_q[k+1] <= a_q[k];
          b_q[k+1] <= b_q[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder_gen.sv
// Self-checking bench for pipe_adder_gen: directed cases, stall, reset and
// random traffic checked against an arithmetic reference model.
module tb_pipe_adder_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] s;
  logic        ovf;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;

  logic [17:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [17:0] prev_val;

  pipe_adder_gen #(
    .N    (16),
    .CHUNK(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] model(logic [15:0] ma, logic [15:0] mb, logic mm, logic mc);
    logic [16:0] r;
    logic        sb;
    logic        o;
    if (mm) begin
      r  = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
      sb = ~mb[15];
    end else begin
      r  = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
      sb = mb[15];
    end
    o = (ma[15] == sb) && (r[15] != ma[15]);
    return {o, r};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(logic v);
    in_valid = v;
    a        = 16'($urandom);
    b        = 16'($urandom);
    mode     = 1'($urandom);
    cin      = 1'($urandom);
  endtask

  // Expects an empty pipe, out_ready high, called just after a rising edge.
  task automatic directed(string name, logic [15:0] ta, logic [15:0] tb_, logic tm, logic tc,
                          logic [17:0] want);
    int n;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    mode     = tm;
    cin      = tc;
    step();
    drive_rand(1'b0);
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check({name, "_latency"}, n, 4);
    check({name, "_value"}, {ovf, s}, want);
    step();
  endtask

  // Scoreboard: handshakes sampled mid-cycle take effect at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_output_held", {ovf, s}, prev_val);
      end
      prev_stall <= out_valid && !out_ready;
      prev_val   <= {ovf, s};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", {ovf, s}, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, mode, cin));
        n_acc++;
      end
    end
  end

  initial begin
    logic [13:0] seen;
    logic [17:0] hold_s;
    int          stale;
    int          cyc;
    int          base;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    mode      = 1'b0;
    cin       = 1'b0;
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_s", s, 0);
    check("reset_ovf", ovf, 0);
    check("reset_in_ready", in_ready, 1);

    check("model_add_wrap", model(16'hFFFF, 16'h0001, 1'b0, 1'b0), 18'h10000);
    check("model_sub_borrow", model(16'h0005, 16'h0007, 1'b1, 1'b0), 18'h0FFFE);
    check("model_sub_noborrow", model(16'h0007, 16'h0005, 1'b1, 1'b1), 18'h10002);
    check("model_add_ovf_pos", model(16'h7FFF, 16'h0001, 1'b0, 1'b0), 18'h28000);
    check("model_add_ovf_neg", model(16'h8000, 16'h8000, 1'b0, 1'b0), 18'h30000);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_release_in_ready", in_ready, 1);

    directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 18'h0FFFE);
    directed("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 18'h10002);
    directed("add_ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    directed("add_ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 18'h30000);
    directed("add_cin", 16'h1234, 16'h0FFF, 1'b0, 1'b1, 18'h02234);

    // Eight back-to-back beats: results occupy exactly cycles 4..11.
    for (int i = 0; i < 14; i++) begin
      if (i < 8) drive_rand(1'b1);
      else in_valid = 1'b0;
      step();
      seen[i] = out_valid;
    end
    check("b2b_valid_window", seen, 14'h0FF0);

    // Fill the pipe against a blocked sink, then hold it.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      step();
    end
    in_valid = 1'b0;
    hold_s   = {ovf, s};
    check("stall_full_valid", out_valid, 1);
    check("stall_occupancy", exp_q.size(), 5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", in_ready, 0);
      check("stall_hold", {ovf, s}, hold_s);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("stall_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 6; i++) begin
      drive_rand(1'b1);
      step();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s", s, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);
    directed("post_reset", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 18'h01000);

    // Random traffic with random backpressure.
    base = n_acc;
    cyc  = 0;
    while ((n_acc - base) < 1000 && cyc < 20000) begin
      drive_rand(($urandom % 4) != 0);
      out_ready = ($urandom % 4) != 0;
      step();
      cyc++;
    end
    check("random_budget", (n_acc - base) >= 1000, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    step();
    check("random_drained", exp_q.size(), 0);
    check("final_idle", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
